ps2_ascii_decoder: RTL and testbench

Downstream consumer of the PS/2 keypress driver. Takes one (scancode, make/break) event per tick and tracks the shift and caps-lock modifier state. Translates make events of printable and control keys (set 2) to 8-bit ASCII and queues them in a small FIFO. The typewriter display/text-buffer logic pops characters with a valid/read handshake.

---
 rtl/ps2_pkg.sv | 18 +
 rtl/ps2_scan2ascii.sv | 94 +++++++++
 rtl/ps2_ascii_decoder.sv | 104 ++++++++++
 tb/tb_ps2_ascii_decoder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 set-2 to ASCII path: modifier and control
// scancodes and the ASCII codes produced for control keys.
package ps2_pkg;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_TAB    = 8'h0D;

  localparam logic [7:0] ASC_CR  = 8'h0D;
  localparam logic [7:0] ASC_BS  = 8'h08;
  localparam logic [7:0] ASC_SP  = 8'h20;
  localparam logic [7:0] ASC_TAB = 8'h09;

endpackage

// File: rtl/ps2_scan2ascii.sv
// Combinational set-2 scancode to ASCII lookup. Letters flip to uppercase
// when shift XOR caps; digits take their shifted symbol on shift only;
// control keys ignore both modifiers. Anything else reports mapped=0.
module ps2_scan2ascii
  import ps2_pkg::*;
(
  input  logic [7:0] code,
  input  logic       shift,
  input  logic       caps,
  output logic [7:0] ascii,
  output logic       mapped
);

  logic [7:0] letter;
  logic       is_letter;
  logic [7:0] digit_plain;
  logic [7:0] digit_shift;
  logic       is_digit;

  // Letter table, lowercase form
  always_comb begin
    is_letter = 1'b1;
    letter    = 8'h00;
    case (code)
      8'h1C: letter = "a";
      8'h32: letter = "b";
      8'h21: letter = "c";
      8'h23: letter = "d";
      8'h24: letter = "e";
      8'h2B: letter = "f";
      8'h34: letter = "g";
      8'h33: letter = "h";
      8'h43: letter = "i";
      8'h3B: letter = "j";
      8'h42: letter = "k";
      8'h4B: letter = "l";
      8'h3A: letter = "m";
      8'h31: letter = "n";
      8'h44: letter = "o";
      8'h4D: letter = "p";
      8'h15: letter = "q";
      8'h2D: letter = "r";
      8'h1B: letter = "s";
      8'h2C: letter = "t";
      8'h3C: letter = "u";
      8'h2A: letter = "v";
      8'h1D: letter = "w";
      8'h22: letter = "x";
      8'h35: letter = "y";
      8'h1A: letter = "z";
      default: is_letter = 1'b0;
    endcase
  end

  // Digit row, plain and shifted symbol
  always_comb begin
    is_digit    = 1'b1;
    digit_plain = 8'h00;
    digit_shift = 8'h00;
    case (code)
      8'h16: begin digit_plain = "1"; digit_shift = "!"; end
      8'h1E: begin digit_plain = "2"; digit_shift = "@"; end
      8'h26: begin digit_plain = "3"; digit_shift = "#"; end
      8'h25: begin digit_plain = "4"; digit_shift = "$"; end
      8'h2E: begin digit_plain = "5"; digit_shift = "%"; end
      8'h36: begin digit_plain = "6"; digit_shift = "^"; end
      8'h3D: begin digit_plain = "7"; digit_shift = "&"; end
      8'h3E: begin digit_plain = "8"; digit_shift = "*"; end
      8'h46: begin digit_plain = "9"; digit_shift = "("; end
      8'h45: begin digit_plain = "0"; digit_shift = ")"; end
      default: is_digit = 1'b0;
    endcase
  end

  // Final selection; lowercase-to-uppercase is a clear of bit 5
  always_comb begin
    ascii  = 8'h00;
    mapped = 1'b1;
    if (is_letter) begin
      ascii = (shift ^ caps) ? (letter & 8'hDF) : letter;
    end else if (is_digit) begin
      ascii = shift ? digit_shift : digit_plain;
    end else begin
      case (code)
        SC_SPACE: ascii = ASC_SP;
        SC_ENTER: ascii = ASC_CR;
        SC_BKSP:  ascii = ASC_BS;
        SC_TAB:   ascii = ASC_TAB;
        default:  mapped = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/ps2_ascii_decoder.sv
// PS/2 key-event to ASCII decoder: tracks shift/caps modifiers, translates
// make events through ps2_scan2ascii and queues characters in a small FIFO
// popped with a valid/read handshake.
// Optional caps-lock tracking is enabled by defining PS2_ASCII_CAPSLOCK_EN;
// without it 8'h58 is just an unmapped code and caps_active stays 0.
module ps2_ascii_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_tick,
  input  logic       key_make,
  input  logic [7:0] key_code,
  input  logic       ascii_rd,
  output logic       ascii_valid,
  output logic [7:0] ascii_data,
  output logic       fifo_full,
  output logic       overflow,
  output logic       shift_active,
  output logic       caps_active
);

  logic             shift_l;
  logic             shift_r;
  logic             caps;
  logic [FIFO_AW:0] wr_ptr;
  logic [FIFO_AW:0] rd_ptr;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [7:0]       lut_ascii;
  logic             lut_mapped;
  logic             empty;
  logic             full;
  logic             push_req;
  logic             do_push;
  logic             do_pop;

  ps2_scan2ascii u_lut (
    .code   (key_code),
    .shift  (shift_l | shift_r),
    .caps   (caps),
    .ascii  (lut_ascii),
    .mapped (lut_mapped)
  );

  // Extra wrap bit on the pointers separates full from empty
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                    (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign push_req = key_tick & key_make & lut_mapped;
  assign do_pop   = ascii_rd & ~empty;
  assign do_push  = push_req & (~full | do_pop);

  // Shift keys follow make/break of either side
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_l <= 1'b0;
      shift_r <= 1'b0;
    end else if (key_tick) begin
      if (key_code == SC_LSHIFT) shift_l <= key_make;
      if (key_code == SC_RSHIFT) shift_r <= key_make;
    end
  end

`ifdef PS2_ASCII_CAPSLOCK_EN
  // Every caps make toggles, including typematic repeats; breaks ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      caps <= 1'b0;
    end else if (key_tick && key_make && (key_code == SC_CAPS)) begin
      caps <= ~caps;
    end
  end
`else
  assign caps = 1'b0;
`endif

  // FIFO pointers and sticky overflow on a dropped character
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (FIFO_AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (FIFO_AW+1)'(1);
      if (push_req && !do_push) overflow <= 1'b1;
    end
  end

  // Storage is data only; occupancy is owned by the pointers
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[FIFO_AW-1:0]] <= lut_ascii;
  end

  assign ascii_valid  = ~empty;
  assign ascii_data   = empty ? 8'h00 : mem[rd_ptr[FIFO_AW-1:0]];
  assign fifo_full    = full;
  assign shift_active = shift_l | shift_r;
  assign caps_active  = caps;

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Bench for ps2_ascii_decoder: directed sequences with literal expectations,
// then random key events and pops compared every cycle against a queue model.
module tb_ps2_ascii_decoder;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_tick;
  logic       key_make;
  logic [7:0] key_code;
  logic       ascii_rd;
  logic       ascii_valid;
  logic [7:0] ascii_data;
  logic       fifo_full;
  logic       overflow;
  logic       shift_active;
  logic       caps_active;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  ps2_ascii_decoder #(.FIFO_DEPTH(DEPTH), .FIFO_AW(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .key_tick     (key_tick),
    .key_make     (key_make),
    .key_code     (key_code),
    .ascii_rd     (ascii_rd),
    .ascii_valid  (ascii_valid),
    .ascii_data   (ascii_data),
    .fifo_full    (fifo_full),
    .overflow     (overflow),
    .shift_active (shift_active),
    .caps_active  (caps_active)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B,
    8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
    8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
    8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
  string digit_plain = "1234567890";
  string digit_shift = "!@#$%^&*()";

  logic [7:0] mq [$];
  bit m_shl, m_shr, m_caps, m_ovf;

  function automatic void xlat(input logic [7:0] code, input bit sh, input bit cp,
                               output bit mapped, output logic [7:0] ch);
    mapped = 0;
    ch = 8'h00;
    for (int i = 0; i < 26; i++)
      if (code == letter_codes[i]) begin
        mapped = 1;
        ch = ((sh ^ cp) ? 8'd65 : 8'd97) + 8'(i);
      end
    for (int i = 0; i < 10; i++)
      if (code == digit_codes[i]) begin
        mapped = 1;
        ch = sh ? digit_shift[i] : digit_plain[i];
      end
    if (code == 8'h29) begin mapped = 1; ch = 8'h20; end
    if (code == 8'h5A) begin mapped = 1; ch = 8'h0D; end
    if (code == 8'h66) begin mapped = 1; ch = 8'h08; end
    if (code == 8'h0D) begin mapped = 1; ch = 8'h09; end
  endfunction

  always @(posedge clk or posedge reset) begin
    bit popping, mp;
    logic [7:0] ch;
    if (reset) begin
      mq.delete();
      m_shl = 0; m_shr = 0; m_caps = 0; m_ovf = 0;
    end else begin
      popping = ascii_rd && (mq.size() > 0);
      if (key_tick) begin
        if (key_code == 8'h12) m_shl = key_make;
        else if (key_code == 8'h59) m_shr = key_make;
`ifdef PS2_ASCII_CAPSLOCK_EN
        else if (key_code == 8'h58) begin
          if (key_make) m_caps = !m_caps;
        end
`endif
        else if (key_make) begin
          xlat(key_code, m_shl | m_shr, m_caps, mp, ch);
          if (mp) begin
            if (mq.size() < DEPTH || popping) mq.push_back(ch);
            else m_ovf = 1;
          end
        end
      end
      if (popping) void'(mq.pop_front());
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_valid", {7'd0, ascii_valid}, {7'd0, mq.size() != 0});
      chk("cyc_data", ascii_data, (mq.size() != 0) ? mq[0] : 8'h00);
      chk("cyc_full", {7'd0, fifo_full}, {7'd0, mq.size() == DEPTH});
      chk("cyc_ovf", {7'd0, overflow}, {7'd0, m_ovf});
      chk("cyc_shift", {7'd0, shift_active}, {7'd0, m_shl | m_shr});
      chk("cyc_caps", {7'd0, caps_active}, {7'd0, m_caps});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit mk, input logic [7:0] code);
    key_tick = 1; key_make = mk; key_code = code;
    step();
    key_tick = 0;
  endtask

  task automatic pop_expect(input string name, input logic [7:0] exp);
    chk({name, "_valid"}, {7'd0, ascii_valid}, 8'd1);
    chk(name, ascii_data, exp);
    ascii_rd = 1;
    step();
    ascii_rd = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    #1;
    chk("rst_valid", {7'd0, ascii_valid}, 8'd0);
    chk("rst_data", ascii_data, 8'h00);
    chk("rst_ovf", {7'd0, overflow}, 8'd0);
    chk("rst_shift", {7'd0, shift_active}, 8'd0);
    chk("rst_caps", {7'd0, caps_active}, 8'd0);
    chk("rst_full", {7'd0, fifo_full}, 8'd0);
    step();
    reset = 0;
    step();
  endtask

  initial begin
    logic [7:0] pool [20] = '{8'h1C, 8'h32, 8'h15, 8'h1A, 8'h44, 8'h16, 8'h45,
      8'h3E, 8'h29, 8'h5A, 8'h66, 8'h0D, 8'h12, 8'h59, 8'h58, 8'h12, 8'h59,
      8'h58, 8'h00, 8'h7E};
    bit caps_on;
`ifdef PS2_ASCII_CAPSLOCK_EN
    caps_on = 1;
`else
    caps_on = 0;
`endif
    reset = 1; key_tick = 0; key_make = 0; key_code = 8'h00; ascii_rd = 0;
    step();
    step();
    reset = 0;
    step();
    cmp_en = 1;
    chk("init_valid", {7'd0, ascii_valid}, 8'd0);

    // Plain 'a', visible one cycle after the tick
    send(1, 8'h1C);
    chk("lat_valid", {7'd0, ascii_valid}, 8'd1);
    send(0, 8'h1C);
    pop_expect("plain_a", 8'h61);
    chk("empty_after", {7'd0, ascii_valid}, 8'd0);

    // Shift applies only while held
    send(1, 8'h12); send(1, 8'h1C); send(0, 8'h1C); send(0, 8'h12); send(1, 8'h1C);
    pop_expect("shift_A", 8'h41);
    pop_expect("unshift_a", 8'h61);

    // Caps sequences (expectations depend on the build)
    send(1, 8'h58); send(0, 8'h58); send(1, 8'h1C);
    pop_expect("caps_A", caps_on ? 8'h41 : 8'h61);
    send(1, 8'h12); send(1, 8'h1C);
    pop_expect("caps_shift_a", caps_on ? 8'h61 : 8'h41);
    send(0, 8'h12); send(1, 8'h16);
    pop_expect("caps_digit", 8'h31);
    send(1, 8'h12); send(1, 8'h16); send(0, 8'h12);
    pop_expect("shift_digit", 8'h21);
    send(1, 8'h58);
    chk("caps_toggle_off", {7'd0, caps_active}, 8'd0);

    // Overflow on the fifth push
    send(1, 8'h5A); send(1, 8'h66); send(1, 8'h29); send(1, 8'h0D); send(1, 8'h16);
    chk("ovf_full", {7'd0, fifo_full}, 8'd1);
    chk("ovf_flag", {7'd0, overflow}, 8'd1);
    pop_expect("q0", 8'h0D);
    pop_expect("q1", 8'h08);
    pop_expect("q2", 8'h20);
    pop_expect("q3", 8'h09);
    chk("drained", {7'd0, ascii_valid}, 8'd0);
    chk("ovf_sticky", {7'd0, overflow}, 8'd1);

    do_reset();

    // Push and pop together while full
    send(1, 8'h32); send(1, 8'h21); send(1, 8'h23); send(1, 8'h24);
    ascii_rd = 1;
    send(1, 8'h1C);
    ascii_rd = 0;
    chk("pp_full", {7'd0, fifo_full}, 8'd1);
    chk("pp_ovf", {7'd0, overflow}, 8'd0);
    pop_expect("pp0", 8'h63);
    pop_expect("pp1", 8'h64);
    pop_expect("pp2", 8'h65);
    pop_expect("pp3", 8'h61);

    // Push with a read while empty: pop ignored
    ascii_rd = 1;
    send(1, 8'h2B);
    ascii_rd = 0;
    pop_expect("empty_pp", 8'h66);

    // Reset mid-stream with modifiers held
    send(1, 8'h12); send(1, 8'h58); send(1, 8'h1C); send(1, 8'h32);
    do_reset();
    send(1, 8'h1C);
    pop_expect("post_rst_a", 8'h61);

    // Random phase
    for (int n = 0; n < 3000; n++) begin
      key_tick = ($urandom_range(0, 2) == 0);
      key_make = ($urandom_range(0, 3) != 0);
      key_code = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 19)];
      ascii_rd = ($urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 499) == 0);
      step();
    end
    key_tick = 0; ascii_rd = 0; reset = 0;
    step();
    step();
    cmp_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
